// File: rtl/disp_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | disp_pkg : shared digit/anode types and helpers for the display scan  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package disp_pkg;
   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = 4;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

   typedef logic [DIGIT_W-1:0] digit_t;

   function automatic logic is_bcd(input digit_t d);
      return (d <= digit_t'(9));
   endfunction
endpackage
`default_nettype wire

// File: rtl/refresh_prescaler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | refresh_prescaler : 0..DIV-1 slot counter, tick at terminal count     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module refresh_prescaler
   import disp_pkg::*;
#(
   parameter int DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick,
   output logic slot_first
);
   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      tick       = (cnt_q == LAST);
      slot_first = (cnt_q == '0);
      cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule
`default_nettype wire

// File: rtl/digit_scan_mux.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | digit_scan_mux : 4-digit multiplexed BCD display scanner, frame-safe  |
// | value commit. Option: LEADING_ZERO_BLANK_EN blanks leading zeros.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module digit_scan_mux
   import disp_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            load_valid,
   input  logic [NUM_DIGITS*DIGIT_W-1:0]   load_data,
   output logic                            load_ready,
   output logic [DIGIT_W-1:0]              digit,
   output logic [NUM_DIGITS-1:0]           an,
   output logic                            frame_start,
   output logic                            bcd_err
);
   localparam int VAL_W = NUM_DIGITS * DIGIT_W;

   logic w_tick;
   logic w_slot_first;

   logic [1:0]            idx_q,         idx_d;
   logic [VAL_W-1:0]      shadow_q,      shadow_d;
   logic [VAL_W-1:0]      display_q,     display_d;
   logic                  pending_q,     pending_d;
   logic                  bcd_err_q,     bcd_err_d;
   logic [DIGIT_W-1:0]    digit_q,       digit_d;
   logic [NUM_DIGITS-1:0] an_q,          an_d;
   logic                  frame_start_q, frame_start_d;

   logic                  w_accept;
   logic                  w_commit;
   logic                  w_shadow_ok;
   logic [NUM_DIGITS-1:0] w_blank;
   logic [NUM_DIGITS-1:0] w_lit;
`ifdef LEADING_ZERO_BLANK_EN
   logic                  w_hi_zero;
`endif

   refresh_prescaler #(
      .DIV        (REFRESH_DIV)
   ) u_prescaler (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (w_tick),
      .slot_first (w_slot_first)
   );

   always_comb begin
      w_accept = load_valid && !pending_q;
      w_commit = w_tick && (idx_q == 2'd3) && pending_q;

      w_shadow_ok = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!is_bcd(shadow_q[i*DIGIT_W +: DIGIT_W])) begin
            w_shadow_ok = 1'b0;
         end
      end

      idx_d     = w_tick ? idx_q + 2'd1 : idx_q;
      shadow_d  = w_accept ? load_data : shadow_q;
      display_d = w_commit ? shadow_q : display_q;
      bcd_err_d = w_commit ? !w_shadow_ok : bcd_err_q;

      pending_d = pending_q;
      if (w_commit) begin
         pending_d = 1'b0;
      end
      if (w_accept) begin
         pending_d = 1'b1;
      end

      // A digit is blank when it and every digit above it are zero.
`ifdef LEADING_ZERO_BLANK_EN
      w_blank   = '0;
      w_hi_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         w_hi_zero  = w_hi_zero && (display_q[i*DIGIT_W +: DIGIT_W] == '0);
         w_blank[i] = w_hi_zero;
      end
`else
      w_blank = '0;
`endif

      w_lit = AN_OFF;
      if (!w_blank[idx_q]) begin
         w_lit[idx_q] = 1'b0;
      end

      // TC loads the dead cycle; the slot's first count lights; else hold.
      if (w_tick) begin
         an_d = AN_OFF;
      end else if (w_slot_first) begin
         an_d = w_lit;
      end else begin
         an_d = an_q;
      end
      digit_d       = w_tick ? display_d[idx_d*DIGIT_W +: DIGIT_W] : digit_q;
      frame_start_d = w_tick && (idx_d == 2'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q         <= 2'd0;
         shadow_q      <= '0;
         display_q     <= '0;
         pending_q     <= 1'b0;
         bcd_err_q     <= 1'b0;
         digit_q       <= '0;
         an_q          <= AN_OFF;
         frame_start_q <= 1'b0;
      end else begin
         idx_q         <= idx_d;
         shadow_q      <= shadow_d;
         display_q     <= display_d;
         pending_q     <= pending_d;
         bcd_err_q     <= bcd_err_d;
         digit_q       <= digit_d;
         an_q          <= an_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign load_ready  = !pending_q;
   assign digit       = digit_q;
   assign an          = an_q;
   assign frame_start = frame_start_q;
   assign bcd_err     = bcd_err_q;
endmodule
`default_nettype wire

// File: tb/tb_digit_scan_mux.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_digit_scan_mux : randomized self-checking bench, REFRESH_DIV = 4   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_digit_scan_mux;
   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b1;
   logic        load_valid = 1'b0;
   logic [15:0] load_data  = 16'h0;
   wire         load_ready;
   wire [3:0]   digit;
   wire [3:0]   an;
   wire         frame_start;
   wire         bcd_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   digit_scan_mux #(.REFRESH_DIV(DIV)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .digit       (digit),
      .an          (an),
      .frame_start (frame_start),
      .bcd_err     (bcd_err)
   );

   // Reference: m_k counts clock edges since reset; slot/phase follow from it.
   int          m_k;
   logic [15:0] m_disp, m_shadow;
   logic        m_pend, m_err;

   function automatic logic has_non_bcd(input logic [15:0] v);
      for (int i = 0; i < 4; i++)
         if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic blanked(input int idx);
`ifdef LEADING_ZERO_BLANK_EN
      return (idx != 0) && ((m_disp >> (4 * idx)) == 16'h0);
`else
      return 1'b0;
`endif
   endfunction

   // {an, digit, frame_start, load_ready, bcd_err}
   function automatic logic [10:0] model_out();
      int idx;
      logic [3:0] e_an, e_dg;
      logic e_fs;
      idx  = (m_k / DIV) % 4;
      e_an = 4'hF;
      e_dg = 4'h0;
      e_fs = 1'b0;
      if (m_k != 0) begin
         e_dg = 4'((m_disp >> (4 * idx)) & 16'hF);
         e_fs = (m_k % FRAME == 0);
         if ((m_k % DIV != 0) && !blanked(idx)) e_an = 4'(~(4'b0001 << idx));
      end
      return {e_an, e_dg, e_fs, !m_pend, m_err};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_k <= 0; m_disp <= 16'h0; m_shadow <= 16'h0; m_pend <= 1'b0; m_err <= 1'b0;
      end else begin
         m_k <= m_k + 1;
         if (((m_k + 1) % FRAME == 0) && m_pend) begin
            m_disp <= m_shadow;
            m_pend <= 1'b0;
            m_err  <= has_non_bcd(m_shadow);
         end
         if (load_valid && !m_pend) begin
            m_shadow <= load_data;
            m_pend   <= 1'b1;
         end
      end
   end

   task automatic offer(input logic [15:0] v, output bit ok);
      int n = 0;
      while (!load_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      ok = load_ready;
      if (ok) begin
         load_valid = 1'b1;
         load_data  = v;
         @(negedge clk);
         load_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [10:0] e;
      bit ok;
      int first_lit = -1;
      offer(16'h9A99, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL reset_offer timeout obs=%0b exp=1", ok); end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         e = model_out(); checks++;
         if ({an, digit, frame_start, load_ready, bcd_err} !== e) begin
            errors++;
            $display("FAIL pre_reset k=%0d obs=%b exp=%b", m_k, {an, digit, frame_start, load_ready, bcd_err}, e);
         end
      end
      offer(16'h0011, ok);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({an, digit, frame_start, load_ready, bcd_err} !== {4'hF, 4'h0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL async_reset obs=%b exp=%b", {an, digit, frame_start, load_ready, bcd_err},
                  {4'hF, 4'h0, 1'b0, 1'b1, 1'b0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (first_lit < 0 && an !== 4'hF) begin
            first_lit = c;
            checks++;
            if (an !== 4'b1110) begin
               errors++;
               $display("FAIL first_lit obs=%b exp=1110", an);
            end
         end
      end
      checks++;
      if (first_lit != 1) begin
         errors++;
         $display("FAIL first_lit_cycle obs=%0d exp=1", first_lit);
      end
   endtask

   task automatic test_scan();
      logic [10:0] e;
      int fs_cnt = 0;
      for (int c = 0; c < 2 * FRAME; c++) begin
         @(negedge clk);
         if (frame_start) fs_cnt++;
         e = model_out(); checks++;
         if ({an, digit, frame_start, load_ready, bcd_err} !== e) begin
            errors++;
            $display("FAIL scan k=%0d obs=%b exp=%b", m_k, {an, digit, frame_start, load_ready, bcd_err}, e);
         end
      end
      checks++;
      if (fs_cnt != 2) begin
         errors++;
         $display("FAIL scan_frame_starts obs=%0d exp=2", fs_cnt);
      end
   endtask

   task automatic test_load_1234();
      logic [10:0] e;
      logic [3:0] want;
      bit ok;
      offer(16'h1234, ok);
      checks++;
      if (!ok || load_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_ready_drop obs=%b exp=0", load_ready);
      end
      for (int c = 0; c < 3 * FRAME; c++) begin
         @(negedge clk);
         e = model_out(); checks++;
         if ({an, digit, frame_start, load_ready, bcd_err} !== e) begin
            errors++;
            $display("FAIL load1234 k=%0d obs=%b exp=%b", m_k, {an, digit, frame_start, load_ready, bcd_err}, e);
         end
         if (m_disp == 16'h1234 && an != 4'hF) begin
            case (an)
               4'b1110: want = 4'h4;
               4'b1101: want = 4'h3;
               4'b1011: want = 4'h2;
               default: want = 4'h1;
            endcase
            checks++;
            if (digit !== want) begin
               errors++;
               $display("FAIL load1234_digit an=%b obs=%h exp=%h", an, digit, want);
            end
         end
      end
   endtask

   task automatic test_load_while_pending();
      logic [10:0] e;
      bit ok;
      bit took = 0;
      offer(16'h2468, ok);
      load_valid = 1'b1;
      load_data  = 16'h5678;
      for (int c = 0; c < 3 * FRAME; c++) begin
         @(negedge clk);
         e = model_out(); checks++;
         if ({an, digit, frame_start, load_ready, bcd_err} !== e) begin
            errors++;
            $display("FAIL pending k=%0d obs=%b exp=%b", m_k, {an, digit, frame_start, load_ready, bcd_err}, e);
         end
         if (took) load_valid = 1'b0;
         if (m_disp == 16'h2468 && !m_pend && load_valid) took = 1;
      end
      load_valid = 1'b0;
      for (int c = 0; c < 2 * FRAME; c++) begin
         @(negedge clk);
         e = model_out(); checks++;
         if ({an, digit, frame_start, load_ready, bcd_err} !== e) begin
            errors++;
            $display("FAIL reoffer k=%0d obs=%b exp=%b", m_k, {an, digit, frame_start, load_ready, bcd_err}, e);
         end
      end
      checks++;
      if (m_disp !== 16'h5678) begin
         errors++;
         $display("FAIL reoffer_committed model=%h exp=5678", m_disp);
      end
   endtask

   task automatic test_bad_bcd();
      logic [10:0] e;
      bit ok;
      offer(16'h12A4, ok);
      for (int c = 0; c < 2 * FRAME + 2; c++) begin
         @(negedge clk);
         e = model_out(); checks++;
         if ({an, digit, frame_start, load_ready, bcd_err} !== e) begin
            errors++;
            $display("FAIL bad_bcd k=%0d obs=%b exp=%b", m_k, {an, digit, frame_start, load_ready, bcd_err}, e);
         end
         if (m_disp == 16'h12A4 && an == 4'b1101) begin
            checks++;
            if (digit !== 4'hA || bcd_err !== 1'b1) begin
               errors++;
               $display("FAIL bad_bcd_slot1 obs=%h/%b exp=a/1", digit, bcd_err);
            end
         end
      end
      offer(16'h0009, ok);
      for (int c = 0; c < 2 * FRAME + 2; c++) @(negedge clk);
      checks++;
      if (bcd_err !== 1'b0) begin
         errors++;
         $display("FAIL bcd_err_clear obs=%b exp=0", bcd_err);
      end
   endtask

   task automatic test_blank();
      logic [10:0] e;
      bit ok;
      logic [15:0] vals [2] = '{16'h0042, 16'h0000};
      for (int v = 0; v < 2; v++) begin
         offer(vals[v], ok);
         for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            e = model_out(); checks++;
            if ({an, digit, frame_start, load_ready, bcd_err} !== e) begin
               errors++;
               $display("FAIL blank v=%h k=%0d obs=%b exp=%b", vals[v], m_k,
                        {an, digit, frame_start, load_ready, bcd_err}, e);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [10:0] e;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         e = model_out(); checks++;
         if ({an, digit, frame_start, load_ready, bcd_err} !== e) begin
            errors++;
            $display("FAIL random k=%0d obs=%b exp=%b", m_k, {an, digit, frame_start, load_ready, bcd_err}, e);
         end
         load_valid = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i < 4; i++) load_data[4*i +: 4] = 4'($urandom_range(0, 9));
         end else begin
            load_data = 16'($urandom);
         end
      end
      load_valid = 1'b0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_scan();
      test_load_1234();
      test_load_while_pending();
      test_bad_bcd();
      test_blank();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/digit_scan_mux.md
# digit_scan_mux

Four-digit time-multiplexed display scanner. It sits directly upstream of the 7-segment decoder (`deco7segment`): it holds a 16-bit BCD value and walks the digits at a programmable refresh rate. Each slot presents one 4-bit digit on `digit` for the decoder's `in`, plus the matching active-low anode enable. New values are accepted through a valid/ready handshake and committed only at frame boundaries, so the display never tears.

## Interface
- `REFRESH_DIV`, 50000, clocks per digit slot (1 kHz slot at 50 MHz); legal range ≥ 2.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  new value offered.
- `load_data`  in  16  BCD digits; digit3 = [15:12] … digit0 = [3:0].
- `load_ready`  out  1  scanner can accept a value.
- `digit`  out  4  current digit nibble, to decoder `in`.
- `an`  out  4  anode enables, active-low; `an[i]` drives digit i.
- `frame_start`  out  1  one-cycle pulse at start of digit-0 slot.
- `bcd_err`  out  1  committed value contains a nibble > 9.

## Operation
- **Reset values:** `load_ready`=1, `digit`=0, `an`=4'b1111, `frame_start`=0, `bcd_err`=0. Internal state also resets: display reg=0, shadow reg=0, pending=0, prescaler=0, digit index=0.
- **Prescaler:** counts 0..REFRESH_DIV-1 and wraps. The terminal count (TC) is prescaler==REFRESH_DIV-1.
- **Digit index:** advances on TC, wrapping 3→0. Scan order is 0,1,2,3,0,…
- **Load handshake:** a transfer occurs when `load_valid && load_ready`.
  - On transfer: shadow←`load_data`, pending←1, and `load_ready` drops the next cycle.
  - While pending, `load_ready`=0 and `load_valid` is ignored.
- **Commit:** occurs on TC with index==3 and pending==1.
  - display←shadow, pending←0, `load_ready`=1 the next cycle.
  - `bcd_err` is updated at the same time: 1 if any shadow nibble > 9, else 0. It holds until the next commit.
- **Simultaneous accept and commit:** commit uses pending as sampled in that cycle. A value accepted in the commit cycle (pending was 0) waits for the following frame boundary.
- **Non-BCD nibbles:** passed to `digit` unchanged. Only `bcd_err` flags them.
- **Reset mid-frame:** all state returns to its reset values asynchronously. Scanning restarts at digit 0, and the shadow value is discarded.

## Timing
- `digit`, `an`, and `frame_start` are registered.
- **Slot structure:** the cycle after TC is the dead cycle (prescaler==0).
  - `digit` = display nibble of the new index.
  - `an` = 4'b1111 (anti-ghosting).
  - From prescaler==1 through TC, `an[idx]`=0 and all other anodes are 1.
- **Slot length:** each slot is REFRESH_DIV cycles, with REFRESH_DIV-1 cycles lit. A frame is 4·REFRESH_DIV cycles.
- **`frame_start`:** high exactly during the dead cycle of slot 0.
  - The display register already holds any value committed at the preceding TC.
  - After reset, the first `frame_start` occurs at the first wrap to index 0, not during reset.
- **Commit latency:** from an accepted load to display is at most 4·REFRESH_DIV+1 cycles.

## Configuration
- **`LEADING_ZERO_BLANK_EN` defined:** digits 3..1 are blanked when their nibble and all higher nibbles are 0.
  - Blanking is evaluated on the display register.
  - A blanked digit keeps its `an` bit at 1 for the whole slot. Timing, `digit`, and `frame_start` are unchanged.
  - Digit 0 is never blanked.
- **Not defined:** all four digits light every frame.

## Structure
- **Package `disp_pkg`:**
  - `NUM_DIGITS`=4
  - `DIGIT_W`=4
  - `AN_OFF`=4'b1111
  - typedef `digit_t` (logic [3:0])
  - function `is_bcd(digit_t)`
- **Sub-module `refresh_prescaler`:** parameter DIV. It holds the 0..DIV-1 counter and outputs a one-cycle `tick` at TC plus a `slot_first` flag (count==0).
- **Top level:** index counter, shadow/display registers, handshake, and output registers.

## Test plan
All scenarios use REFRESH_DIV=4.
- **Reset:** assert `rst_n`=0 mid-run → `an`=1111, `digit`=0, `load_ready`=1, `bcd_err`=0 immediately (async). After release, the first lit anode is `an`=1110.
- **Scan:** run 2 frames with display=0 → `an` sequence per slot is 1111,1110,1110,1110, then 1111,1101×3, 1111,1011×3, 1111,0111×3. `frame_start` pulses every 16 cycles.
- **Load 16'h1234:** → `load_ready` drops next cycle. Display changes only after the next digit-3 TC. The following frame shows `digit` 4,3,2,1 for `an` 1110,1101,1011,0111.
- **Load while pending:** offer 16'h5678 while `load_ready`=0 → ignored. The 16'h1234 commit is unaffected, and a re-offer is accepted after `load_ready` returns.
- **Bad BCD:** load 16'h12A4 → after commit, `bcd_err`=1 and `digit`=4'hA in the digit-1 slot. A subsequent load of 16'h0009 clears `bcd_err` at its commit.
- **Blanking (macro defined):** load 16'h0042 → slots 3 and 2 keep `an`=1111 for the whole slot, while slots 1 and 0 light. Load 16'h0000 → only digit 0 lights.
